// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the sprite pipeline / HUD and the frame-level game controller.
// With GAME_PAUSE_EN defined, the pause request and paused status are added.
interface game_state_ctrl_if;
`ifdef GAME_PAUSE_EN
  logic       i_pause;
  logic       o_paused;
`endif
  logic       i_v_sync;
  logic       i_start;
  logic       i_penguin_hit;
  logic       i_obstacle_hit;
  logic       i_crushed;
  logic       o_is_dead;
  logic       o_is_finished;
  logic [2:0] o_lives;
  logic [7:0] o_score;
  logic       o_flash;
  logic [2:0] o_state;

  // Drives the controller inputs (sprite pipeline, HUD, testbench).
  modport master (
`ifdef GAME_PAUSE_EN
    output i_pause,
    input  o_paused,
`endif
    output i_v_sync, i_start, i_penguin_hit, i_obstacle_hit, i_crushed,
    input  o_is_dead, o_is_finished, o_lives, o_score, o_flash, o_state
  );

  // The controller itself.
  modport slave (
`ifdef GAME_PAUSE_EN
    input  i_pause,
    output o_paused,
`endif
    input  i_v_sync, i_start, i_penguin_hit, i_obstacle_hit, i_crushed,
    output o_is_dead, o_is_finished, o_lives, o_score, o_flash, o_state
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Frame-level game controller: lives, score, invulnerability blink and end-of-game states,
// all updated once per rising edge of v_sync. Optional pause support under GAME_PAUSE_EN.
module game_state_ctrl #(
  parameter int unsigned LIVES            = 3,
  parameter int unsigned SCORE_GOAL       = 10,
  parameter int unsigned INVULN_FRAMES    = 60,
  parameter int unsigned DEAD_HOLD_FRAMES = 180
) (
  input logic               i_clk,
  input logic               i_rst,
  game_state_ctrl_if.slave  bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PLAY     = 3'd1;
  localparam logic [2:0] ST_HIT      = 3'd2;
  localparam logic [2:0] ST_DEAD     = 3'd3;
  localparam logic [2:0] ST_FINISHED = 3'd4;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] GOAL       = 8'(SCORE_GOAL);
  localparam logic [7:0] INV_INIT   = 8'(INVULN_FRAMES);
  localparam logic [9:0] HOLD_INIT  = 10'(DEAD_HOLD_FRAMES);

  logic [2:0] state_q, state_d;
  logic       vs_q;
  logic       cr_q, cr_d;
  logic       coll_q, coll_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [7:0] invuln_q, invuln_d;
  logic [9:0] hold_q, hold_d;
  logic       frame_tick;
  logic       crush_evt;
  logic       freeze;
  logic [7:0] score_inc;
`ifdef GAME_PAUSE_EN
  logic       paused_q, paused_d;
`endif

  assign frame_tick = bus.i_v_sync & ~vs_q;
  assign crush_evt  = bus.i_crushed & ~cr_q;
  assign score_inc  = (score_q >= GOAL) ? GOAL : score_q + 8'd1;

`ifdef GAME_PAUSE_EN
  assign freeze = bus.i_pause & ((state_q == ST_PLAY) | (state_q == ST_HIT));
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cr_d     = cr_q;
    lives_d  = lives_q;
    score_d  = score_q;
    invuln_d = invuln_q;
    hold_d   = hold_q;
`ifdef GAME_PAUSE_EN
    paused_d = paused_q;
`endif
    // An overlap on the tick cycle itself belongs to the new frame.
    coll_d = (frame_tick ? 1'b0 : coll_q) |
             ((state_q == ST_PLAY) & bus.i_penguin_hit & bus.i_obstacle_hit);

    if (frame_tick) begin
      cr_d = bus.i_crushed;
`ifdef GAME_PAUSE_EN
      paused_d = freeze;
`endif
      if (!freeze) begin
        case (state_q)
          ST_IDLE: begin
            if (bus.i_start) begin
              state_d = ST_PLAY;
              lives_d = LIVES_INIT;
              score_d = 8'd0;
            end
          end
          ST_PLAY: begin
            if (crush_evt) begin
              score_d = score_inc;
              if (score_inc == GOAL) state_d = ST_FINISHED;
            end else if (coll_q) begin
              if (lives_q <= 3'd1) begin
                lives_d = 3'd0;
                state_d = ST_DEAD;
                hold_d  = HOLD_INIT;
              end else begin
                lives_d  = lives_q - 3'd1;
                state_d  = ST_HIT;
                invuln_d = INV_INIT;
              end
            end
          end
          ST_HIT: begin
            if (crush_evt) begin
              score_d = score_inc;
            end
            if (crush_evt && (score_inc == GOAL)) begin
              state_d = ST_FINISHED;
            end else begin
              invuln_d = invuln_q - 8'd1;
              if (invuln_d == 8'd0) state_d = ST_PLAY;
            end
          end
          ST_DEAD: begin
            hold_d = hold_q - 10'd1;
            // Reload lives here so a zero count is only ever visible in DEAD.
            if (hold_d == 10'd0) begin
              state_d = ST_IDLE;
              lives_d = LIVES_INIT;
            end
          end
          ST_FINISHED: begin
            if (bus.i_start) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      vs_q     <= 1'b0;
      cr_q     <= 1'b0;
      coll_q   <= 1'b0;
      lives_q  <= LIVES_INIT;
      score_q  <= 8'd0;
      invuln_q <= 8'd0;
      hold_q   <= 10'd0;
`ifdef GAME_PAUSE_EN
      paused_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vs_q     <= bus.i_v_sync;
      cr_q     <= cr_d;
      coll_q   <= coll_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      invuln_q <= invuln_d;
      hold_q   <= hold_d;
`ifdef GAME_PAUSE_EN
      paused_q <= paused_d;
`endif
    end
  end

  assign bus.o_state       = state_q;
  assign bus.o_is_dead     = (state_q == ST_DEAD);
  assign bus.o_is_finished = (state_q == ST_FINISHED);
  assign bus.o_lives       = lives_q;
  assign bus.o_score       = score_q;
  assign bus.o_flash       = (state_q == ST_HIT) & invuln_q[3];
`ifdef GAME_PAUSE_EN
  assign bus.o_paused      = paused_q;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed self-checking bench for game_state_ctrl; pause scenario runs when GAME_PAUSE_EN is set.
module tb_game_state_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .LIVES            (3),
    .SCORE_GOAL       (10),
    .INVULN_FRAMES    (60),
    .DEAD_HOLD_FRAMES (180)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame: a single-cycle v_sync pulse followed by three quiet cycles.
  task automatic tick();
    bus.i_v_sync = 1'b1;
    step();
    bus.i_v_sync = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_vsync();
    bus.i_v_sync = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.i_v_sync = 1'b0;
    step();
  endtask

  task automatic overlap();
    bus.i_penguin_hit  = 1'b1;
    bus.i_obstacle_hit = 1'b1;
    step();
    bus.i_penguin_hit  = 1'b0;
    bus.i_obstacle_hit = 1'b0;
    step();
  endtask

  initial begin
    bus.i_v_sync       = 1'b1;
    bus.i_start        = 1'b0;
    bus.i_penguin_hit  = 1'b0;
    bus.i_obstacle_hit = 1'b0;
    bus.i_crushed      = 1'b0;
`ifdef GAME_PAUSE_EN
    bus.i_pause        = 1'b0;
`endif
    step(); step(); step();
    chk("rst_state", 32'(bus.o_state), 0);
    chk("rst_lives", 32'(bus.o_lives), 3);
    chk("rst_score", 32'(bus.o_score), 0);
    chk("rst_flash", 32'(bus.o_flash), 0);
    chk("rst_dead", 32'(bus.o_is_dead), 0);
    chk("rst_fin", 32'(bus.o_is_finished), 0);
`ifdef GAME_PAUSE_EN
    chk("rst_paused", 32'(bus.o_paused), 0);
`endif
    bus.i_v_sync = 1'b0;
    rst = 1'b0;
    step();

    tick();
    chk("idle_no_start", 32'(bus.o_state), 0);

    // Start: visible only after the tick edge.
    bus.i_start  = 1'b1;
    bus.i_v_sync = 1'b1;
    #1;
    chk("start_latency", 32'(bus.o_state), 0);
    step();
    bus.i_v_sync = 1'b0;
    bus.i_start  = 1'b0;
    chk("start_state", 32'(bus.o_state), 1);
    chk("start_lives", 32'(bus.o_lives), 3);
    chk("start_score", 32'(bus.o_score), 0);
    step(); step(); step();

    // First collision: PLAY -> HIT, invuln 60 (bit3 set).
    overlap();
    tick();
    chk("hit1_lives", 32'(bus.o_lives), 2);
    chk("hit1_state", 32'(bus.o_state), 2);
    chk("hit1_flash", 32'(bus.o_flash), 1);
    overlap();
    tick_n(5);
    chk("hit_flash55", 32'(bus.o_flash), 0);
    chk("hit_no_loss", 32'(bus.o_lives), 2);
    tick_n(8);
    chk("hit_flash47", 32'(bus.o_flash), 1);
    hold_vsync();
    tick_n(45);
    chk("hit_still59", 32'(bus.o_state), 2);
    tick();
    chk("hit_expire", 32'(bus.o_state), 1);
    chk("hit_exp_flash", 32'(bus.o_flash), 0);

    // Overlap on the tick cycle itself counts toward the next frame.
    bus.i_v_sync       = 1'b1;
    bus.i_penguin_hit  = 1'b1;
    bus.i_obstacle_hit = 1'b1;
    step();
    bus.i_v_sync       = 1'b0;
    bus.i_penguin_hit  = 1'b0;
    bus.i_obstacle_hit = 1'b0;
    step(); step();
    chk("edge_ov_state", 32'(bus.o_state), 1);
    chk("edge_ov_lives", 32'(bus.o_lives), 2);
    tick();
    chk("hit2_lives", 32'(bus.o_lives), 1);
    chk("hit2_state", 32'(bus.o_state), 2);
    tick_n(60);
    chk("hit2_expire", 32'(bus.o_state), 1);

    // Final collision with start held: DEAD for 180 ticks.
    bus.i_start = 1'b1;
    overlap();
    tick();
    chk("dead_lives", 32'(bus.o_lives), 0);
    chk("dead_state", 32'(bus.o_state), 3);
    chk("dead_flag", 32'(bus.o_is_dead), 1);
    tick_n(179);
    chk("dead_hold179", 32'(bus.o_state), 3);
    tick();
    chk("dead_to_idle", 32'(bus.o_state), 0);
    chk("dead_flag_clr", 32'(bus.o_is_dead), 0);
    tick();
    bus.i_start = 1'b0;
    chk("restart_state", 32'(bus.o_state), 1);
    chk("restart_lives", 32'(bus.o_lives), 3);
    chk("restart_score", 32'(bus.o_score), 0);

    // Crushed held for 5 frames scores once.
    bus.i_crushed = 1'b1;
    tick_n(5);
    chk("crush_held", 32'(bus.o_score), 1);
    bus.i_crushed = 1'b0;
    tick();
    for (int k = 2; k <= 9; k++) begin
      bus.i_crushed = 1'b1;
      tick();
      chk("crush_pulse", 32'(bus.o_score), 32'(k));
      bus.i_crushed = 1'b0;
      tick();
    end
    chk("crush_state9", 32'(bus.o_state), 1);
    overlap();
    bus.i_crushed = 1'b1;
    tick();
    bus.i_crushed = 1'b0;
    chk("goal_score", 32'(bus.o_score), 10);
    chk("goal_state", 32'(bus.o_state), 4);
    chk("goal_fin", 32'(bus.o_is_finished), 1);
    chk("goal_lives", 32'(bus.o_lives), 3);
    bus.i_crushed = 1'b1;
    tick();
    bus.i_crushed = 1'b0;
    tick();
    chk("fin_hold", 32'(bus.o_state), 4);
    chk("fin_score_sat", 32'(bus.o_score), 10);
    bus.i_start = 1'b1;
    tick();
    chk("fin_to_idle", 32'(bus.o_state), 0);
    chk("idle_score_kept", 32'(bus.o_score), 10);
    tick();
    bus.i_start = 1'b0;
    chk("play_score_clr", 32'(bus.o_score), 0);

    // Mid-game reset with v_sync low.
    overlap();
    tick();
    chk("pre_rst_state", 32'(bus.o_state), 2);
    rst = 1'b1;
    step();
    chk("mid_rst_state", 32'(bus.o_state), 0);
    chk("mid_rst_lives", 32'(bus.o_lives), 3);
    chk("mid_rst_flash", 32'(bus.o_flash), 0);
    rst = 1'b0;
    step();

`ifdef GAME_PAUSE_EN
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    overlap();
    tick();
    tick_n(30);
    chk("pz_pre_state", 32'(bus.o_state), 2);
    bus.i_pause = 1'b1;
    tick_n(10);
    overlap();
    tick_n(10);
    chk("pz_paused", 32'(bus.o_paused), 1);
    chk("pz_state", 32'(bus.o_state), 2);
    chk("pz_lives", 32'(bus.o_lives), 2);
    chk("pz_flash30", 32'(bus.o_flash), 1);
    bus.i_pause = 1'b0;
    tick_n(29);
    chk("pz_unpaused", 32'(bus.o_paused), 0);
    chk("pz_inv_kept", 32'(bus.o_state), 2);
    tick();
    chk("pz_expire", 32'(bus.o_state), 1);
    bus.i_pause = 1'b1;
    overlap();
    tick();
    bus.i_pause = 1'b0;
    tick();
    chk("pz_play_lives", 32'(bus.o_lives), 2);
    chk("pz_play_state", 32'(bus.o_state), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
